decoder_1ri20_queue: RTL and testbench
======================================

DECODER_1RI20_QUEUE -- requirements
Module: decoder_1ri20_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning instructions accepted/emitted per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, >= 2*LANES.
REQ-003 SHALL have parameter PRECOMPUTE, default 1, meaning 1 = compute the result in-queue, 0 = out_result forced to 0.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous queue clear.
REQ-007 SHALL have port in_valid, input, LANES, per-lane push request.
REQ-008 SHALL have ports in_pc and in_inst, input, LANES*32 each, lane i at bits [32i+31:32i].
REQ-009 SHALL have port in_ready, output, 1, high when free entries >= LANES.
REQ-010 SHALL have port out_valid, output, LANES, lane i holds the i-th oldest entry.
REQ-011 SHALL have port out_ready, input, LANES, per-lane pop acknowledge.
REQ-012 SHALL have ports out_pc, out_inst, out_result, output, LANES*32 each.
REQ-013 SHALL have port out_rd, output, LANES*5, which is inst[4:0].
REQ-014 SHALL have port out_kind, output, LANES*2, encoded 0 LU12I.W, 1 PCADDI, 2 PCALAU12I, 3 PCADDU12I.
REQ-015 SHALL have port out_inst_valid, output, LANES, high when opcode is recognised.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1, current occupancy.

Function
REQ-017 Opcode SHALL be inst[31:25] and si20 SHALL be inst[24:5], with 0001010 = LU12I.W, 0001100 = PCADDI, 0001101 = PCALAU12I, 0001110 = PCADDU12I.
REQ-018 Result SHALL be: LU12I {si20,12'b0}; PCADDI pc+sext({si20,2'b0}); PCADDU12I pc+{si20,12'b0}; PCALAU12I (pc+{si20,12'b0}) & 32'hFFFF_F000; all mod 2^32.
REQ-019 Unrecognised opcode SHALL be enqueued with out_inst_valid=0, out_kind=0 and out_result=0.
REQ-020 Decode and result SHALL be computed on push and stored with the entry.
REQ-021 Push set SHALL be the contiguous prefix of in_valid from lane 0; lanes after the first 0 are ignored.
REQ-022 Push SHALL occur only when in_ready=1; in_ready SHALL be derived from registered count (pre-pop), never from same-cycle pops.
REQ-023 out_valid[i] SHALL equal (count > i).
REQ-024 Pop set SHALL be the contiguous prefix of (out_valid & out_ready).
REQ-025 Simultaneous push and pop SHALL both take effect: count_next = count + pushed - popped.
REQ-026 Latency SHALL be push at edge T, visible on out_* after edge T with no same-cycle bypass.
REQ-027 Order SHALL be strict FIFO across lanes; lane 0 of a push is older than lane 1.
REQ-028 Read/write pointers SHALL wrap modulo DEPTH.
REQ-029 Data outputs of a lane SHALL be 0 whenever that lane's out_valid=0.
REQ-030 flush SHALL zero pointers and count at the next edge, discard same-cycle pushes and pops, and drive out_valid=0 the following cycle.
REQ-031 flush SHALL take priority over push and pop; rst SHALL take priority over flush.

Reset
REQ-032 While rst=1 and after rst deasserts, state SHALL be pointers=0, count=0, out_valid=0, all data outputs=0, in_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all entries immediately, asynchronously, with no partial pop.

Verification
REQ-034 Push lane0 inst={0001010,20'h12345,5'd4} -> next cycle out_valid=01, out_result=0x12345000, out_rd=4, out_kind=0.
REQ-035 Push pc=0x1C000000 PCADDU12I si20=1 with lane1 pc=0x1C000010 PCADDI si20=0xFFFFF -> results 0x1C001000 and 0x1C00000C, order preserved.
REQ-036 PCALAU12I pc=0x1C000ABC si20=1 -> 0x1C001000; PRECOMPUTE=0 build -> 0.
REQ-037 LANES=2, DEPTH=4: two full pushes with out_ready=0 -> count=4, in_ready=0; a third push is ignored; popping 1 leaves in_ready=0 (needs 2 free); popping 2 then restores in_ready.
REQ-038 in_valid=10 -> nothing pushed; out_ready=10 with 2 valid -> nothing popped.
REQ-039 flush concurrent with a push at count=3 -> count=0 and out_valid=00 next cycle; rst pulse mid-burst -> REQ-032 state immediately.

Source files
------------

// File: rtl/decoder_1ri20_queue.sv
// Multi-lane FIFO for LoongArch 1RI20 instructions (LU12I.W, PCADDI, PCALAU12I, PCADDU12I).
// The result is decoded when an entry is pushed and stored with it, so the pop side is a plain read.
module decoder_1ri20_queue #(
    parameter int LANES      = 2,
    parameter int DEPTH      = 4,
    parameter int PRECOMPUTE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*32-1:0]        in_pc,
    input  logic [LANES*32-1:0]        in_inst,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    input  logic [LANES-1:0]           out_ready,
    output logic [LANES*32-1:0]        out_pc,
    output logic [LANES*32-1:0]        out_inst,
    output logic [LANES*32-1:0]        out_result,
    output logic [LANES*5-1:0]         out_rd,
    output logic [LANES*2-1:0]         out_kind,
    output logic [LANES-1:0]           out_inst_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic [1:0]  kind;
        logic        vld;
    } entry_t;

    entry_t           mem_r [DEPTH];
    entry_t           new_entry_s [LANES];
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    push_n_s;
    logic [CW-1:0]    pop_n_s;
    logic             in_ready_s;
    logic [LANES-1:0] out_valid_s;

    // Decode one instruction into a queue entry; unknown opcodes keep kind/result at zero.
    function automatic entry_t decode_entry(input logic [31:0] pc, input logic [31:0] inst);
        entry_t      e;
        logic [31:0] upper;
        logic [31:0] offset;
        logic [31:0] sum;
        upper    = {inst[24:5], 12'd0};
        offset   = {{10{inst[24]}}, inst[24:5], 2'b00};
        sum      = pc + upper;
        e.pc     = pc;
        e.inst   = inst;
        e.kind   = 2'd0;
        e.vld    = 1'b0;
        e.result = 32'd0;
        case (inst[31:25])
            7'b0001010: begin e.vld = 1'b1; e.kind = 2'd0; e.result = upper; end
            7'b0001100: begin e.vld = 1'b1; e.kind = 2'd1; e.result = pc + offset; end
            7'b0001101: begin e.vld = 1'b1; e.kind = 2'd2; e.result = sum & 32'hFFFF_F000; end
            7'b0001110: begin e.vld = 1'b1; e.kind = 2'd3; e.result = sum; end
            default:    begin e.vld = 1'b0; e.kind = 2'd0; e.result = 32'd0; end
        endcase
        e.result = (PRECOMPUTE != 0) ? e.result : 32'd0;
        return e;
    endfunction

    assign in_ready_s = ((CW'(DEPTH) - count_r) >= CW'(LANES));

    // Push/pop sizes: contiguous prefixes from lane 0; ready uses the registered count only.
    always_comb begin
        logic push_run;
        logic pop_run;
        push_n_s = '0;
        pop_n_s  = '0;
        push_run = 1'b1;
        pop_run  = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            out_valid_s[i] = (count_r > CW'(i));
            new_entry_s[i] = decode_entry(in_pc[32*i +: 32], in_inst[32*i +: 32]);
            if (push_run && in_valid[i]) begin
                push_n_s = push_n_s + CW'(1);
            end else begin
                push_run = 1'b0;
            end
            if (pop_run && out_valid_s[i] && out_ready[i]) begin
                pop_n_s = pop_n_s + CW'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
        push_n_s = in_ready_s ? push_n_s : '0;
    end

    // Queue storage, pointers and occupancy; flush discards both sides of the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                mem_r[d] <= '0;
            end
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (CW'(i) < push_n_s) begin
                    mem_r[wr_ptr_r + PW'(i)] <= new_entry_s[i];
                end
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_n_s);
            rd_ptr_r <= rd_ptr_r + PW'(pop_n_s);
            count_r  <= count_r + push_n_s - pop_n_s;
        end
    end

    // Present the oldest entries on the output lanes, zeroing any lane without a valid entry.
    always_comb begin
        entry_t e;
        out_pc         = '0;
        out_inst       = '0;
        out_result     = '0;
        out_rd         = '0;
        out_kind       = '0;
        out_inst_valid = '0;
        for (int i = 0; i < LANES; i++) begin
            e = mem_r[rd_ptr_r + PW'(i)];
            if (out_valid_s[i]) begin
                out_pc[32*i +: 32]  = e.pc;
                out_inst[32*i +: 32] = e.inst;
                out_result[32*i +: 32] = e.result;
                out_rd[5*i +: 5]    = e.inst[4:0];
                out_kind[2*i +: 2]  = e.kind;
                out_inst_valid[i]   = e.vld;
            end else begin
                out_inst_valid[i]   = 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign count     = count_r;

endmodule

// File: tb/tb_decoder_1ri20_queue.sv
// Directed, table-driven bench for decoder_1ri20_queue (LANES=2, DEPTH=4) plus a PRECOMPUTE=0 copy.
module tb_decoder_1ri20_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_inst;
    logic [1:0]  out_ready;
    logic        in_ready, p0_in_ready;
    logic [1:0]  out_valid, p0_out_valid;
    logic [63:0] out_pc, out_inst, out_result;
    logic [63:0] p0_pc, p0_inst, p0_result;
    logic [9:0]  out_rd, p0_rd;
    logic [3:0]  out_kind, p0_kind;
    logic [1:0]  out_inst_valid, p0_inst_valid;
    logic [2:0]  count, p0_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decoder_1ri20_queue #(.LANES(2), .DEPTH(4), .PRECOMPUTE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_result(out_result), .out_rd(out_rd),
        .out_kind(out_kind), .out_inst_valid(out_inst_valid), .count(count)
    );

    decoder_1ri20_queue #(.LANES(2), .DEPTH(4), .PRECOMPUTE(0)) dut_p0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_ready(p0_in_ready), .out_valid(p0_out_valid), .out_ready(out_ready),
        .out_pc(p0_pc), .out_inst(p0_inst), .out_result(p0_result), .out_rd(p0_rd),
        .out_kind(p0_kind), .out_inst_valid(p0_inst_valid), .count(p0_count)
    );

    typedef struct {
        logic [1:0]  iv;
        logic [31:0] pc0, i0, pc1, i1;
        logic [1:0]  ordy;
        logic        fl;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic [1:0]  e_ov;
        logic [31:0] e_r0, e_r1;
        logic [4:0]  e_rd0;
        logic [1:0]  e_k0;
        logic        e_iv0;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [19:0] si, input logic [4:0] rd);
        return {op, si, rd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] cnt, input logic rdy,
                               input logic [1:0] ov, input logic [31:0] r0, input logic [31:0] r1);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, " result0"}, out_result[31:0], r0);
        chk({tag, " result1"}, out_result[63:32], r1);
    endtask

    initial begin
        logic [31:0] lu_a, pcu, pcad, pcal, unk, lu_m, lu_1, lu_2, lu_3, pcad2;
        lu_a  = mk(7'b0001010, 20'h12345, 5'd4);
        pcu   = mk(7'b0001110, 20'h00001, 5'd1);
        pcad  = mk(7'b0001100, 20'hFFFFF, 5'd2);
        pcal  = mk(7'b0001101, 20'h00001, 5'd3);
        unk   = mk(7'h7F, 20'h0ABCD, 5'd7);
        lu_m  = mk(7'b0001010, 20'hFFFFF, 5'd5);
        lu_1  = mk(7'b0001010, 20'h00001, 5'd6);
        lu_2  = mk(7'b0001010, 20'h00002, 5'd1);
        lu_3  = mk(7'b0001010, 20'h00003, 5'd8);
        pcad2 = mk(7'b0001100, 20'h00001, 5'd9);

        //          iv     pc0           i0     pc1           i1     ordy   fl    cnt   rdy   ov     r0             r1             rd0   k0     iv0
        vecs[0]  = '{2'b01, 32'h0,        lu_a,  32'h0,        32'h0, 2'b00, 1'b0, 3'd1, 1'b1, 2'b01, 32'h12345000, 32'h0,        5'd4, 2'd0, 1'b1};
        vecs[1]  = '{2'b00, 32'h0,        32'h0, 32'h0,        32'h0, 2'b01, 1'b0, 3'd0, 1'b1, 2'b00, 32'h0,        32'h0,        5'd0, 2'd0, 1'b0};
        vecs[2]  = '{2'b11, 32'h1C000000, pcu,   32'h1C000010, pcad,  2'b00, 1'b0, 3'd2, 1'b1, 2'b11, 32'h1C001000, 32'h1C00000C, 5'd1, 2'd3, 1'b1};
        vecs[3]  = '{2'b11, 32'h1C000ABC, pcal,  32'h100,      unk,   2'b00, 1'b0, 3'd4, 1'b0, 2'b11, 32'h1C001000, 32'h1C00000C, 5'd1, 2'd3, 1'b1};
        vecs[4]  = '{2'b11, 32'h1C000ABC, pcal,  32'h100,      unk,   2'b00, 1'b0, 3'd4, 1'b0, 2'b11, 32'h1C001000, 32'h1C00000C, 5'd1, 2'd3, 1'b1};
        vecs[5]  = '{2'b00, 32'h0,        32'h0, 32'h0,        32'h0, 2'b10, 1'b0, 3'd4, 1'b0, 2'b11, 32'h1C001000, 32'h1C00000C, 5'd1, 2'd3, 1'b1};
        vecs[6]  = '{2'b00, 32'h0,        32'h0, 32'h0,        32'h0, 2'b01, 1'b0, 3'd3, 1'b0, 2'b11, 32'h1C00000C, 32'h1C001000, 5'd2, 2'd1, 1'b1};
        vecs[7]  = '{2'b00, 32'h0,        32'h0, 32'h0,        32'h0, 2'b11, 1'b0, 3'd1, 1'b1, 2'b01, 32'h0,        32'h0,        5'd7, 2'd0, 1'b0};
        vecs[8]  = '{2'b10, 32'h0,        lu_a,  32'h0,        lu_a,  2'b00, 1'b0, 3'd1, 1'b1, 2'b01, 32'h0,        32'h0,        5'd7, 2'd0, 1'b0};
        vecs[9]  = '{2'b11, 32'h2000,     lu_m,  32'h2004,     lu_1,  2'b01, 1'b0, 3'd2, 1'b1, 2'b11, 32'hFFFFF000, 32'h00001000, 5'd5, 2'd0, 1'b1};
        vecs[10] = '{2'b01, 32'h0,        lu_a,  32'h0,        32'h0, 2'b00, 1'b1, 3'd0, 1'b1, 2'b00, 32'h0,        32'h0,        5'd0, 2'd0, 1'b0};
        vecs[11] = '{2'b11, 32'h0,        lu_2,  32'h0,        lu_3,  2'b00, 1'b0, 3'd2, 1'b1, 2'b11, 32'h00002000, 32'h00003000, 5'd1, 2'd0, 1'b1};
        vecs[12] = '{2'b01, 32'h10,       pcad2, 32'h0,        32'h0, 2'b00, 1'b0, 3'd3, 1'b0, 2'b11, 32'h00002000, 32'h00003000, 5'd1, 2'd0, 1'b1};
        vecs[13] = '{2'b11, 32'h10,       pcad2, 32'h10,       pcad2, 2'b11, 1'b1, 3'd0, 1'b1, 2'b00, 32'h0,        32'h0,        5'd0, 2'd0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 2'b00; in_pc = '0; in_inst = '0; out_ready = 2'b00;
        @(posedge clk); #1;
        check_state("reset", 3'd0, 1'b1, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 14; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            @(negedge clk);
            in_valid  = vecs[v].iv;
            in_pc     = {vecs[v].pc1, vecs[v].pc0};
            in_inst   = {vecs[v].i1, vecs[v].i0};
            out_ready = vecs[v].ordy;
            flush     = vecs[v].fl;
            @(posedge clk); #1;
            check_state(tag, vecs[v].e_cnt, vecs[v].e_rdy, vecs[v].e_ov, vecs[v].e_r0, vecs[v].e_r1);
            chk({tag, " rd0"}, 32'(out_rd[4:0]), 32'(vecs[v].e_rd0));
            chk({tag, " kind0"}, 32'(out_kind[1:0]), 32'(vecs[v].e_k0));
            chk({tag, " inst_valid0"}, 32'(out_inst_valid[0]), 32'(vecs[v].e_iv0));
            chk({tag, " p0 result"}, p0_result[31:0] | p0_result[63:32], 32'h0);
            chk({tag, " p0 count"}, 32'(p0_count), 32'(vecs[v].e_cnt));
        end

        // PCALAU12I reaches lane 0 of both builds: decoded result vs forced zero.
        @(negedge clk);
        flush = 1'b0; out_ready = 2'b00; in_valid = 2'b01;
        in_pc = {32'h0, 32'h1C000ABC}; in_inst = {32'h0, pcal};
        @(posedge clk); #1;
        chk("pcalau12i result", out_result[31:0], 32'h1C001000);
        chk("pcalau12i kind", 32'(out_kind[1:0]), 32'd2);
        chk("pcalau12i p0 result", p0_result[31:0], 32'h0);
        chk("pcalau12i p0 kind", 32'(p0_kind[1:0]), 32'd2);

        // Asynchronous reset mid-burst: state clears before any clock edge.
        @(negedge clk);
        in_valid = 2'b11; in_pc = {32'h4, 32'h0}; in_inst = {lu_1, lu_2};
        @(posedge clk); #1;
        chk("burst count", 32'(count), 32'd3);
        #2;
        rst = 1'b1; out_ready = 2'b11;
        #1;
        check_state("async rst", 3'd0, 1'b1, 2'b00, 32'h0, 32'h0);
        chk("async rst rd", 32'(out_rd), 32'd0);
        chk("async rst pc", out_pc[31:0] | out_pc[63:32], 32'h0);
        @(negedge clk);
        rst = 1'b0; in_valid = 2'b00; out_ready = 2'b00;
        @(posedge clk); #1;
        check_state("post rst", 3'd0, 1'b1, 2'b00, 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
